r2n_buffer_o: RTL and testbench

Ready-to-normal output buffer. It sits after the multi-core matrix-multiplication array and accepts its block-per-block result stream: one beat carries one BLOCK_SIZE×BLOCK_SIZE block per core. It reassembles the stream into full normal-order rows of COL elements and emits them one row per handshake to the downstream row-oriented stage.

---
 rtl/r2n_buffer_o_if.sv | 30 +++
 rtl/r2n_buffer_o.sv | 153 +++++++++++++++
 tb/tb_r2n_buffer_o.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/r2n_buffer_o_if.sv
// Handshake bundle for the ready-to-normal output buffer: block-beat input side,
// normal-order row output side, and the start/status strobes.
interface r2n_buffer_o_if #(
  parameter int WIDTH      = 16,
  parameter int CHUNK_SIZE = 4,
  parameter int NUM_CORES  = 4,
  parameter int COL        = 64,
  parameter int ROW        = 256
);
  logic                                   en;
  logic                                   in_valid;
  logic                                   in_ready;
  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0]  in_r2n_buffer;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [WIDTH*COL-1:0]                   out_r2n_buffer;
  logic [$clog2(ROW)-1:0]                 out_row_idx;
  logic                                   slice_done;
  logic                                   buffer_done;

  modport slave (
    input  en, in_valid, in_r2n_buffer, out_ready,
    output in_ready, out_valid, out_r2n_buffer, out_row_idx, slice_done, buffer_done
  );

  modport master (
    output en, in_valid, in_r2n_buffer, out_ready,
    input  in_ready, out_valid, out_r2n_buffer, out_row_idx, slice_done, buffer_done
  );
endinterface

// File: rtl/r2n_buffer_o.sv
// Ready-to-normal output buffer: gathers one slab of block-per-core beats into
// SLICE_ROWS row registers, then drains them as full normal-order rows.
module r2n_buffer_o #(
  parameter int WIDTH      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int BLOCK_SIZE = 2,
  parameter int CHUNK_SIZE = 4,
  parameter int ROW        = 256,
  parameter int COL        = 64,
  parameter int NUM_CORES  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  r2n_buffer_o_if.slave bus
);

  localparam int SLICE_ROWS = BLOCK_SIZE * NUM_CORES;
  localparam int BEATS      = COL / BLOCK_SIZE;
  localparam int SLABS      = ROW / SLICE_ROWS;
  localparam int CHUNK_W    = CHUNK_SIZE * WIDTH;
  localparam int RW         = (SLICE_ROWS > 1) ? $clog2(SLICE_ROWS) : 1;
  localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW         = (SLABS > 1) ? $clog2(SLABS) : 1;
  localparam int IDX_W      = $clog2(ROW);

  // Geometry that the beat/row mapping below silently relies on.
  if (CHUNK_SIZE != BLOCK_SIZE * BLOCK_SIZE || (ROW % SLICE_ROWS) != 0 ||
      (COL % BLOCK_SIZE) != 0 || FRAC_WIDTH >= WIDTH) begin : g_bad_params
    $error("r2n_buffer_o: inconsistent parameters");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [BW-1:0]        beat_cnt_r;
  logic [RW-1:0]        row_cnt_r;
  logic [SW-1:0]        slab_cnt_r;
  logic                 slice_done_r;
  logic [WIDTH*COL-1:0] slab_mem_r [SLICE_ROWS];

  logic in_fire_s;
  logic out_fire_s;
  logic last_beat_s;
  logic last_row_s;
  logic last_slab_s;
  int   col_base_s;
  int   row_idx_s;

  // Handshake qualifiers and counter terminal conditions.
  always_comb begin
    in_fire_s   = (state_r == COLLECT) && bus.in_valid;
    out_fire_s  = (state_r == DRAIN) && bus.out_ready;
    last_beat_s = (beat_cnt_r == BW'(BEATS - 1));
    last_row_s  = (row_cnt_r == RW'(SLICE_ROWS - 1));
    last_slab_s = (slab_cnt_r == SW'(SLABS - 1));
    col_base_s  = BLOCK_SIZE * int'(beat_cnt_r);
    row_idx_s   = int'(slab_cnt_r) * SLICE_ROWS + int'(row_cnt_r);
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.en) state_s = COLLECT;
        else        state_s = IDLE;
      end
      COLLECT: begin
        if (in_fire_s && last_beat_s) state_s = DRAIN;
        else                          state_s = COLLECT;
      end
      DRAIN: begin
        if (out_fire_s && last_row_s) begin
          if (last_slab_s) state_s = DONE;
          else             state_s = COLLECT;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode straight from registered state; no path from in_valid/out_ready.
  always_comb begin
    bus.in_ready       = 1'b0;
    bus.out_valid      = 1'b0;
    bus.out_r2n_buffer = '0;
    bus.out_row_idx    = '0;
    bus.buffer_done    = 1'b0;
    bus.slice_done     = slice_done_r;
    case (state_r)
      COLLECT: bus.in_ready = 1'b1;
      DRAIN: begin
        bus.out_valid      = 1'b1;
        bus.out_r2n_buffer = slab_mem_r[row_cnt_r];
        bus.out_row_idx    = IDX_W'(row_idx_s);
      end
      DONE:    bus.buffer_done = 1'b1;
      default: bus.in_ready = 1'b0;
    endcase
  end

  // State register and beat/row/slab counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      beat_cnt_r   <= '0;
      row_cnt_r    <= '0;
      slab_cnt_r   <= '0;
      slice_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      slice_done_r <= 1'b0;
      if (in_fire_s) begin
        if (last_beat_s) beat_cnt_r <= '0;
        else             beat_cnt_r <= beat_cnt_r + BW'(1);
      end
      if (out_fire_s) begin
        if (last_row_s) begin
          row_cnt_r    <= '0;
          slab_cnt_r   <= slab_cnt_r + SW'(1);
          slice_done_r <= 1'b1;
        end else begin
          row_cnt_r <= row_cnt_r + RW'(1);
        end
      end
    end
  end

  // Slab storage: scatter each core's block into its BLOCK_SIZE rows at this beat's columns.
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        for (int r = 0; r < BLOCK_SIZE; r++) begin
          for (int c = 0; c < BLOCK_SIZE; c++) begin
            slab_mem_r[k*BLOCK_SIZE + r][(COL - 1 - col_base_s - c)*WIDTH +: WIDTH] <=
              bus.in_r2n_buffer[(NUM_CORES - 1 - k)*CHUNK_W +
                                (CHUNK_SIZE - 1 - (r*BLOCK_SIZE + c))*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_r2n_buffer_o.sv
// Directed scoreboard bench for r2n_buffer_o with ROW=8, COL=4, BLOCK_SIZE=2,
// NUM_CORES=2, WIDTH=16.
module tb_r2n_buffer_o;

  localparam int W   = 16;
  localparam int BS  = 2;
  localparam int NC  = 2;
  localparam int CS  = 4;
  localparam int RWS = 8;
  localparam int CL  = 4;

  typedef struct packed {
    logic [2:0]  idx;
    logic [63:0] row;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  exp_t exp_q[$];

  r2n_buffer_o_if #(.WIDTH(W), .CHUNK_SIZE(CS), .NUM_CORES(NC), .COL(CL), .ROW(RWS)) bus ();

  r2n_buffer_o #(
    .WIDTH(W), .FRAC_WIDTH(8), .BLOCK_SIZE(BS), .CHUNK_SIZE(CS),
    .ROW(RWS), .COL(CL), .NUM_CORES(NC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Element value of core k, block element e, in beat b of a slab starting at base.
  function automatic logic [127:0] pack_beat(input int base, input int b);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < NC; k++)
      for (int e = 0; e < CS; e++)
        v[(NC-1-k)*64 + (CS-1-e)*16 +: 16] = 16'(base + b*8 + k*4 + e + 1);
    return v;
  endfunction

  // Normal-order row R, derived by locating each column's source core/beat/element.
  function automatic logic [63:0] exp_row(input int base, input int r_i);
    logic [63:0] v;
    int k, r, b, c;
    v = '0;
    for (int col = 0; col < CL; col++) begin
      k = r_i / BS;
      r = r_i % BS;
      b = col / BS;
      c = col % BS;
      v[(CL-1-col)*16 +: 16] = 16'(base + b*8 + k*4 + r*BS + c + 1);
    end
    return v;
  endfunction

  task automatic send_slab(input int base, input int slab, input int gap);
    int cyc;
    exp_t it;
    for (int b = 0; b < 2; b++) begin
      if (b == 1) begin
        for (int g = 0; g < gap; g++) begin
          bus.in_valid = 1'b0;
          step();
          chk("gap_in_ready", 64'(bus.in_ready), 64'd1);
        end
      end
      bus.in_valid      = 1'b1;
      bus.in_r2n_buffer = pack_beat(base, b);
      cyc = 0;
      while (!bus.in_ready && cyc < 50) begin
        step();
        cyc++;
      end
      chk("beat_accept", 64'(bus.in_ready), 64'd1);
      step();
    end
    bus.in_valid      = 1'b0;
    bus.in_r2n_buffer = '0;
    for (int r = 0; r < 4; r++) begin
      it.idx = 3'(slab*4 + r);
      it.row = exp_row(base, r);
      exp_q.push_back(it);
    end
    chk("first_row_valid", 64'(bus.out_valid), 64'd1);
    chk("collect_end_in_ready", 64'(bus.in_ready), 64'd0);
  endtask

  task automatic drain(input int nrows, input logic [3:0] pat, input int patlen);
    int got, cyc;
    got = 0;
    cyc = 0;
    while (got < nrows && cyc < 100 && exp_q.size() > 0) begin
      bus.out_ready = pat[cyc % patlen];
      chk("drain_valid", 64'(bus.out_valid), 64'd1);
      chk("drain_in_ready", 64'(bus.in_ready), 64'd0);
      chk("drain_row", bus.out_r2n_buffer, exp_q[0].row);
      chk("drain_idx", 64'(bus.out_row_idx), 64'(exp_q[0].idx));
      chk("drain_slice_done", 64'(bus.slice_done), 64'd0);
      step();
      if (bus.out_ready) begin
        void'(exp_q.pop_front());
        got++;
      end
      cyc++;
    end
    bus.out_ready = 1'b0;
    chk("drain_rows_done", 64'(got), 64'(nrows));
    chk("slice_done_pulse", 64'(bus.slice_done), 64'd1);
    chk("after_drain_valid", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    n_pass            = 0;
    n_total           = 0;
    rst_n             = 1'b0;
    bus.en            = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_r2n_buffer = '0;
    bus.out_ready     = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_slice_done", 64'(bus.slice_done), 64'd0);
    chk("rst_buffer_done", 64'(bus.buffer_done), 64'd0);
    chk("rst_out_data", bus.out_r2n_buffer, 64'd0);
    chk("rst_out_idx", 64'(bus.out_row_idx), 64'd0);
    rst_n = 1'b1;

    // Idle: in_valid without en is ignored
    bus.in_valid      = 1'b1;
    bus.in_r2n_buffer = pack_beat(0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_in_ready", 64'(bus.in_ready), 64'd0);
      chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
    end
    bus.in_valid = 1'b0;

    // Start and single slab at full rate
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    chk("en_in_ready", 64'(bus.in_ready), 64'd1);
    send_slab(0, 0, 0);
    chk("slab0_row0_literal", bus.out_r2n_buffer, 64'h0001_0002_0009_000a);
    drain(4, 4'b1111, 1);
    chk("slab0_buffer_done", 64'(bus.buffer_done), 64'd0);
    chk("slab0_back_to_collect", 64'(bus.in_ready), 64'd1);
    step();
    chk("slice_done_single", 64'(bus.slice_done), 64'd0);

    // Second slab (+16) with backpressure 1,0,0,1
    send_slab(16, 1, 0);
    drain(4, 4'b1001, 4);
    chk("final_buffer_done", 64'(bus.buffer_done), 64'd1);
    bus.en            = 1'b1;
    bus.in_valid      = 1'b1;
    bus.in_r2n_buffer = pack_beat(40, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("done_hold", 64'(bus.buffer_done), 64'd1);
      chk("done_in_ready", 64'(bus.in_ready), 64'd0);
      chk("done_out_valid", 64'(bus.out_valid), 64'd0);
    end
    bus.en       = 1'b0;
    bus.in_valid = 1'b0;

    // Restart, then reset mid-drain after row 1
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("restart_done_cleared", 64'(bus.buffer_done), 64'd0);
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    send_slab(0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      bus.out_ready = 1'b1;
      chk("partial_row", bus.out_r2n_buffer, exp_q[0].row);
      chk("partial_idx", 64'(bus.out_row_idx), 64'(exp_q[0].idx));
      step();
      void'(exp_q.pop_front());
    end
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("midrst_out_data", bus.out_r2n_buffer, 64'd0);
    chk("midrst_out_idx", 64'(bus.out_row_idx), 64'd0);
    bus.in_valid      = 1'b1;
    bus.in_r2n_buffer = pack_beat(0, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("midrst_needs_en", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;

    // Fresh slab with a 3-cycle input gap; rows must match the single-slab case
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    send_slab(0, 0, 3);
    drain(4, 4'b1111, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
